// File: rtl/seg7_reader.sv
// Monitor-side decoder for an active-low seven-segment bus. It debounces the pattern,
// decodes it back to a hex nibble and strobes every accepted change.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             err,
    output logic             blank,
    output logic             locked,
    output logic [CNT_W-1:0] change_cnt
);

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    localparam logic [8:0] STABLE_MAX9 = 9'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam bit         SINGLE      = (STABLE_CYCLES == 1);

    state_t           r_state;
    logic [6:0]       r_seg_q;
    logic [6:0]       r_cand;
    logic [6:0]       r_acc_pat;
    logic             r_acc_valid;
    logic             r_primed;
    logic [7:0]       r_cnt;
    logic [3:0]       r_digit;
    logic             r_digit_valid;
    logic             r_err;
    logic             r_blank;
    logic             r_locked;
    logic [CNT_W-1:0] r_change_cnt;

    logic             w_changed;
    logic             w_direct;
    logic             w_do_accept;
    logic             w_new_pat;
    logic [6:0]       w_accept_pat;
    logic [5:0]       w_decoded;

    // Result packing is {err, blank, digit}.
    function automatic logic [5:0] decode(input logic [6:0] pat);
        logic [5:0] res;
        res = 6'b00_0000;
        case (pat)
            7'h40: res[3:0] = 4'h0;
            7'h79: res[3:0] = 4'h1;
            7'h24: res[3:0] = 4'h2;
            7'h30: res[3:0] = 4'h3;
            7'h19: res[3:0] = 4'h4;
            7'h12: res[3:0] = 4'h5;
            7'h02: res[3:0] = 4'h6;
            7'h78: res[3:0] = 4'h7;
            7'h00: res[3:0] = 4'h8;
            7'h10: res[3:0] = 4'h9;
            7'h08: res[3:0] = 4'hA;
            7'h03: res[3:0] = 4'hB;
            7'h46: res[3:0] = 4'hC;
            7'h21: res[3:0] = 4'hD;
            7'h06: res[3:0] = 4'hE;
            7'h0E: res[3:0] = 4'hF;
            7'h7F: res = 6'b01_0000;
            default: res = 6'b10_0000;
        endcase
        return res;
    endfunction

    // With a one-sample requirement a fresh pattern is accepted on sight, except right
    // after a strobe, where it takes one extra cycle so strobes never touch.
    always_comb begin
        w_changed    = (r_seg_q != r_cand);
        w_direct     = SINGLE && !r_digit_valid;
        w_do_accept  = 1'b0;
        w_accept_pat = r_cand;
        case (r_state)
            IDLE: begin
                if (r_primed && SINGLE) begin
                    w_do_accept  = 1'b1;
                    w_accept_pat = r_seg_q;
                end
            end
            SETTLE: begin
                if (w_changed) begin
                    if (w_direct) begin
                        w_do_accept  = 1'b1;
                        w_accept_pat = r_seg_q;
                    end
                end else if (({1'b0, r_cnt} + 9'd1) >= STABLE_MAX9) begin
                    w_do_accept = 1'b1;
                end
            end
            LOCKED: begin
                if (w_changed && w_direct) begin
                    w_do_accept  = 1'b1;
                    w_accept_pat = r_seg_q;
                end
            end
            default: ;
        endcase
        w_new_pat = !r_acc_valid || (w_accept_pat != r_acc_pat);
        w_decoded = decode(w_accept_pat);
    end

    // IDLE waits one cycle so the input register holds a real sample before it is trusted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_seg_q       <= 7'h00;
            r_cand        <= 7'h00;
            r_acc_pat     <= 7'h00;
            r_acc_valid   <= 1'b0;
            r_primed      <= 1'b0;
            r_cnt         <= 8'd0;
            r_digit       <= 4'h0;
            r_digit_valid <= 1'b0;
            r_err         <= 1'b0;
            r_blank       <= 1'b0;
            r_locked      <= 1'b0;
            r_change_cnt  <= '0;
        end else begin
            r_seg_q       <= seg_in;
            r_primed      <= 1'b1;
            r_digit_valid <= 1'b0;
            if (w_do_accept && w_new_pat) begin
                r_acc_pat     <= w_accept_pat;
                r_acc_valid   <= 1'b1;
                r_err         <= w_decoded[5];
                r_blank       <= w_decoded[4];
                r_digit       <= w_decoded[3:0];
                r_digit_valid <= 1'b1;
                r_change_cnt  <= r_change_cnt + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (r_primed) begin
                        r_cand <= r_seg_q;
                        r_cnt  <= 8'd1;
                        if (w_do_accept) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end else begin
                            r_state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (w_changed) begin
                        r_cand <= r_seg_q;
                        r_cnt  <= 8'd1;
                        if (w_do_accept) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else if (w_do_accept) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                        r_cnt    <= STABLE_MAX;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                LOCKED: begin
                    if (w_changed) begin
                        r_cand <= r_seg_q;
                        r_cnt  <= 8'd1;
                        if (!w_do_accept) begin
                            r_state  <= SETTLE;
                            r_locked <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign digit       = r_digit;
    assign digit_valid = r_digit_valid;
    assign err         = r_err;
    assign blank       = r_blank;
    assign locked      = r_locked;
    assign change_cnt  = r_change_cnt;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: two instances (4-sample/8-bit counter and 1-sample/2-bit counter)
// compared every cycle against a run-length model, plus directed hand-checked scenarios.
module tb_seg7_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] segA;
    logic [6:0] segB;

    logic [3:0] digitA, digitB;
    logic       validA, validB, errA, errB, blankA, blankB, lockedA, lockedB;
    logic [7:0] cntA;
    logic [1:0] cntB;

    always #5 clk = ~clk;

    seg7_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dutA (
        .clk(clk), .reset(reset), .seg_in(segA), .digit(digitA), .digit_valid(validA),
        .err(errA), .blank(blankA), .locked(lockedA), .change_cnt(cntA)
    );

    seg7_reader #(.STABLE_CYCLES(1), .CNT_W(2)) dutB (
        .clk(clk), .reset(reset), .seg_in(segB), .digit(digitB), .digit_valid(validB),
        .err(errB), .blank(blankB), .locked(lockedB), .change_cnt(cntB)
    );

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int relBase = 0;
    int strobesA = 0;
    int strobesB = 0;
    int strobeCycA = -1;
    bit sawUnlockA = 0;
    int qDigitA[$];
    int qCntB[$];

    typedef struct {
        logic [6:0] last;
        int         run;
        logic [6:0] accPat;
        bit         accValid;
        int         digit;
        bit         err;
        bit         blank;
        bit         valid;
        bit         locked;
        int         cnt;
    } ModelT;

    ModelT mA, mB;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelClear(output ModelT m);
        m.last = 7'h00;
        m.run = 0;
        m.accPat = 7'h00;
        m.accValid = 0;
        m.digit = 0;
        m.err = 0;
        m.blank = 0;
        m.valid = 0;
        m.locked = 0;
        m.cnt = 0;
    endtask

    // run counts consecutive identical samples; a pattern is taken the edge after its run hits the threshold.
    task automatic modelEdge(inout ModelT m, input logic [6:0] s, input int stable);
        bit found;
        m.valid = 0;
        if (m.run == stable && (!m.accValid || m.accPat != m.last)) begin
            m.digit = 0;
            m.err = 0;
            m.blank = 0;
            if (m.last == 7'h7F) begin
                m.blank = 1;
            end else begin
                found = 0;
                for (int i = 0; i < 16; i++) begin
                    if (glyph[i] == m.last) begin
                        m.digit = i;
                        found = 1;
                    end
                end
                m.err = !found;
            end
            m.accPat = m.last;
            m.accValid = 1;
            m.valid = 1;
            m.cnt++;
        end
        m.locked = (m.run >= stable);
        if (m.run > 0 && s == m.last) begin
            if (m.run < 1000) m.run++;
        end else begin
            m.run = 1;
            m.last = s;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            modelClear(mA);
            modelClear(mB);
        end else begin
            modelEdge(mA, segA, 4);
            modelEdge(mB, segB, 1);
        end
    end

    always @(negedge clk) begin
        checkOutput("A.digit", int'(digitA), mA.digit);
        checkOutput("A.valid", int'(validA), int'(mA.valid));
        checkOutput("A.err", int'(errA), int'(mA.err));
        checkOutput("A.blank", int'(blankA), int'(mA.blank));
        checkOutput("A.locked", int'(lockedA), int'(mA.locked));
        checkOutput("A.cnt", int'(cntA), mA.cnt % 256);
        checkOutput("B.digit", int'(digitB), mB.digit);
        checkOutput("B.valid", int'(validB), int'(mB.valid));
        checkOutput("B.err", int'(errB), int'(mB.err));
        checkOutput("B.blank", int'(blankB), int'(mB.blank));
        checkOutput("B.locked", int'(lockedB), int'(mB.locked));
        checkOutput("B.cnt", int'(cntB), mB.cnt % 4);
        if (validA === 1'b1) begin
            strobesA++;
            qDigitA.push_back(int'(digitA));
            if (strobeCycA < 0) strobeCycA = cyc - relBase;
        end
        if (validB === 1'b1) begin
            strobesB++;
            qCntB.push_back(int'(cntB));
        end
        if (lockedA === 1'b0) sawUnlockA = 1;
    end

    task automatic applyStimulus(input logic [6:0] a, input logic [6:0] b, input int n);
        segA = a;
        segB = b;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clearCounters();
        strobesA = 0;
        strobesB = 0;
        strobeCycA = -1;
        sawUnlockA = 0;
        qDigitA.delete();
        qCntB.delete();
        relBase = cyc;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst.digitA", int'(digitA), 0);
        checkOutput("rst.validA", int'(validA), 0);
        checkOutput("rst.lockedA", int'(lockedA), 0);
        checkOutput("rst.cntA", int'(cntA), 0);
        checkOutput("rst.digitB", int'(digitB), 0);
        checkOutput("rst.cntB", int'(cntB), 0);
    endtask

    function automatic logic [6:0] pickSeg();
        int k;
        logic [6:0] v;
        k = $urandom_range(0, 17);
        if (k < 16) v = glyph[k];
        else if (k == 16) v = 7'h7F;
        else v = 7'($urandom);
        return v;
    endfunction

    initial begin
        int expSeq[5];
        expSeq = '{1, 2, 3, 0, 1};
        segA = 7'h21;
        segB = 7'h40;
        #1 reset = 1'b0;
        @(posedge clk);
        #2;
        applyStimulus(7'h21, 7'h40, 2);
        checkResetOutputs();

        // d held on A; B alternates 0/1 to walk its 2-bit counter through a wrap.
        reset = 1'b1;
        clearCounters();
        applyStimulus(7'h21, 7'h40, 3);
        applyStimulus(7'h21, 7'h79, 3);
        applyStimulus(7'h21, 7'h40, 3);
        applyStimulus(7'h21, 7'h79, 3);
        applyStimulus(7'h21, 7'h40, 3);
        checkOutput("A.firstStrobes", strobesA, 1);
        checkOutput("A.latency", strobeCycA, 5);
        checkOutput("A.firstDigit", int'(digitA), 13);
        checkOutput("A.firstErr", int'(errA), 0);
        checkOutput("A.firstCnt", int'(cntA), 1);
        checkOutput("model.A.digit", mA.digit, 13);
        checkOutput("B.seqLen", qCntB.size(), 5);
        for (int i = 0; i < 5 && i < qCntB.size(); i++)
            checkOutput("B.cntSeq", qCntB[i], expSeq[i]);

        clearCounters();
        applyStimulus(7'h08, 7'h40, 2);
        applyStimulus(7'h21, 7'h40, 10);
        checkOutput("A.glitchStrobes", strobesA, 0);
        checkOutput("A.glitchUnlock", int'(sawUnlockA), 1);
        checkOutput("A.glitchRelock", int'(lockedA), 1);
        checkOutput("A.glitchDigit", int'(digitA), 13);
        checkOutput("A.glitchCnt", int'(cntA), 1);

        clearCounters();
        for (int i = 0; i < 16; i++) applyStimulus(glyph[i], glyph[i], 10);
        checkOutput("A.sweepStrobes", strobesA, 16);
        for (int i = 0; i < 16 && i < qDigitA.size(); i++)
            checkOutput("A.sweepOrder", qDigitA[i], i);
        checkOutput("A.sweepCnt", int'(cntA), 17);
        checkOutput("model.A.cnt", mA.cnt, 17);

        clearCounters();
        applyStimulus(7'h7F, 7'h7F, 10);
        checkOutput("A.blankBlank", int'(blankA), 1);
        checkOutput("A.blankDigit", int'(digitA), 0);
        checkOutput("A.blankErr", int'(errA), 0);
        applyStimulus(7'h55, 7'h55, 10);
        checkOutput("A.errErr", int'(errA), 1);
        checkOutput("A.errBlank", int'(blankA), 0);
        checkOutput("A.errDigit", int'(digitA), 0);
        checkOutput("A.errStrobes", strobesA, 2);
        checkOutput("A.errCnt", int'(cntA), 19);

        // Reset lands while A is still settling on 2.
        applyStimulus(7'h24, 7'h24, 2);
        reset = 1'b0;
        applyStimulus(7'h24, 7'h24, 3);
        checkResetOutputs();
        reset = 1'b1;
        clearCounters();
        applyStimulus(7'h24, 7'h24, 10);
        checkOutput("A.rstStrobes", strobesA, 1);
        checkOutput("A.rstLatency", strobeCycA, 5);
        checkOutput("A.rstDigit", int'(digitA), 2);
        checkOutput("A.rstCnt", int'(cntA), 1);

        for (int n = 0; n < 250; n++) begin
            logic [6:0] a;
            logic [6:0] b;
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                applyStimulus(segA, segB, 2);
                reset = 1'b1;
            end
            a = pickSeg();
            b = pickSeg();
            applyStimulus(a, b, $urandom_range(2, 9));
        end
        applyStimulus(segA, segB, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
